// File: rtl/pathtracer_wb_bridge_pkg.sv
// Shared constants for the Pathtracer Wishbone bridge: channel widths,
// register offsets within the 32-byte window and STAT bit positions.
package pathtracer_pkg;

    localparam int CMD_W = 12;
    localparam int PIX_W = 24;

    localparam logic [4:0] OFS_CMD  = 5'h00;
    localparam logic [4:0] OFS_PIX  = 5'h04;
    localparam logic [4:0] OFS_STAT = 5'h08;
    localparam logic [4:0] OFS_PCNT = 5'h0C;
    localparam logic [4:0] OFS_CTRL = 5'h10;

    localparam int STAT_CMD_FULL  = 16;
    localparam int STAT_PIX_EMPTY = 17;
    localparam int STAT_CMD_OVF   = 18;
    localparam int STAT_PIX_UNF   = 19;

endpackage

// File: rtl/pathtracer_wb_bridge_if.sv
// Wishbone slave bus bundle between the management SoC and the bridge.
interface pathtracer_wb_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/pathtracer_wb_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next pointer values from the qualified push/pop strobes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/pathtracer_wb_bridge.sv
// Wishbone slave bridge: CPU-written commands are queued and streamed to the
// Pathtracer input channel; Pathtracer pixels are queued for the CPU to read.
module pathtracer_wb_bridge
    import pathtracer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CMD_DEPTH = 8,
    parameter int          PIX_DEPTH = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    pathtracer_wb_bridge_if.slave wb,
    output logic [CMD_W-1:0]      pt_in_dat,
    output logic                  pt_in_vld,
    input  logic                  pt_in_rdy,
    input  logic [PIX_W-1:0]      pt_px_dat,
    input  logic                  pt_px_vld,
    output logic                  pt_px_rdy,
    output logic                  irq
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int PAW = $clog2(PIX_DEPTH);

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             cmd_ovf_q, cmd_ovf_d;
    logic             pix_unf_q, pix_unf_d;
    logic [31:0]      pcnt_q, pcnt_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;

    logic             req, in_win;
    logic [4:0]       ofs;
    logic             wr_cmd, rd_pix, wr_stat, wr_pcnt, wr_ctrl;
    logic             cmd_push, cmd_pop, pix_push, pix_pop;
    logic [CMD_W-1:0] cmd_head;
    logic [PIX_W-1:0] pix_head;
    logic [CAW:0]     cmd_count;
    logic [PAW:0]     pix_count;
    logic             cmd_full, cmd_empty, pix_full, pix_empty;
    logic [31:0]      stat_word;
    logic [31:0]      rdata;
    logic             unused_bits;

    // Requests are blocked during the ack cycle so a held strobe runs once.
    assign req    = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
    assign in_win = (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign ofs    = wb.wbs_adr_i[4:0];

    assign wr_cmd  = req & in_win &  wb.wbs_we_i & (ofs == OFS_CMD);
    assign rd_pix  = req & in_win & ~wb.wbs_we_i & (ofs == OFS_PIX);
    assign wr_stat = req & in_win &  wb.wbs_we_i & (ofs == OFS_STAT);
    assign wr_pcnt = req & in_win &  wb.wbs_we_i & (ofs == OFS_PCNT);
    assign wr_ctrl = req & in_win &  wb.wbs_we_i & (ofs == OFS_CTRL);

    // Full is judged on the registered state, so a write racing a drain is dropped.
    assign cmd_push = wr_cmd & ~cmd_full;
    assign cmd_pop  = pt_in_vld & pt_in_rdy;
    assign pix_push = pt_px_vld & pt_px_rdy;
    assign pix_pop  = rd_pix & ~pix_empty;

    assign pt_in_vld = ~cmd_empty;
    assign pt_in_dat = cmd_empty ? '0 : cmd_head;
    assign pt_px_rdy = ~pix_full & ~wb_rst_i;
    assign irq       = irq_q;

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    assign unused_bits = &{1'b0, wb.wbs_sel_i, wb.wbs_dat_i};

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .push_i     (cmd_push),
        .push_dat_i (wb.wbs_dat_i[CMD_W-1:0]),
        .pop_i      (cmd_pop),
        .head_o     (cmd_head),
        .count_o    (cmd_count),
        .full_o     (cmd_full),
        .empty_o    (cmd_empty)
    );

    sync_fifo #(.WIDTH(PIX_W), .DEPTH(PIX_DEPTH)) u_pix_fifo (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .push_i     (pix_push),
        .push_dat_i (pt_px_dat),
        .pop_i      (pix_pop),
        .head_o     (pix_head),
        .count_o    (pix_count),
        .full_o     (pix_full),
        .empty_o    (pix_empty)
    );

    assign stat_word = {12'd0, pix_unf_q, cmd_ovf_q, pix_empty, cmd_full,
                        8'(pix_count), 8'(cmd_count)};

    // Read mux: snapshot of the register taken at the request sample edge.
    always_comb begin
        rdata = '0;
        if (in_win && !wb.wbs_we_i) begin
            case (ofs)
                OFS_PIX:  rdata = pix_empty ? 32'd0 : {1'b1, 7'd0, pix_head};
                OFS_STAT: rdata = stat_word;
                OFS_PCNT: rdata = pcnt_q;
                OFS_CTRL: rdata = {31'd0, irq_en_q};
                default:  rdata = '0;
            endcase
        end
    end

    // Next-state for bus response, sticky flags, pixel counter and control.
    always_comb begin
        ack_d     = req;
        dat_d     = req ? rdata : 32'd0;
        cmd_ovf_d = cmd_ovf_q;
        pix_unf_d = pix_unf_q;
        pcnt_d    = pcnt_q;
        irq_en_d  = irq_en_q;

        if (wr_stat && wb.wbs_dat_i[STAT_CMD_OVF]) cmd_ovf_d = 1'b0;
        if (wr_stat && wb.wbs_dat_i[STAT_PIX_UNF]) pix_unf_d = 1'b0;
        if (wr_cmd && cmd_full)                    cmd_ovf_d = 1'b1;
        if (rd_pix && pix_empty)                   pix_unf_d = 1'b1;

        if (wr_pcnt)       pcnt_d = 32'd0;
        else if (pix_push) pcnt_d = pcnt_q + 32'd1;

        if (wr_ctrl) irq_en_d = wb.wbs_dat_i[0];

        irq_d = irq_en_q & ~pix_empty;
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            cmd_ovf_q <= 1'b0;
            pix_unf_q <= 1'b0;
            pcnt_q    <= 32'd0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            cmd_ovf_q <= cmd_ovf_d;
            pix_unf_q <= pix_unf_d;
            pcnt_q    <= pcnt_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_pathtracer_wb_bridge.sv
// Directed bench for the Pathtracer Wishbone bridge.
module tb_pathtracer_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [11:0] pt_in_dat;
    logic        pt_in_vld;
    logic        pt_in_rdy = 1'b0;
    logic [23:0] pt_px_dat = '0;
    logic        pt_px_vld = 1'b0;
    logic        pt_px_rdy;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc_cnt   = 0;
    int vld_cycles = 0;
    logic [11:0] sent_q[$];
    int          sent_t[$];

    pathtracer_wb_bridge_if wb_if ();

    pathtracer_wb_bridge #(.BASE_ADDR(BASE), .CMD_DEPTH(8), .PIX_DEPTH(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wb        (wb_if.slave),
        .pt_in_dat (pt_in_dat),
        .pt_in_vld (pt_in_vld),
        .pt_in_rdy (pt_in_rdy),
        .pt_px_dat (pt_px_dat),
        .pt_px_vld (pt_px_vld),
        .pt_px_rdy (pt_px_rdy),
        .irq       (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    always @(negedge wb_clk_i) begin
        if (pt_in_vld) vld_cycles++;
        if (pt_in_vld && pt_in_rdy) begin
            sent_q.push_back(pt_in_dat);
            sent_t.push_back(cyc_cnt);
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr,
                           input logic [31:0] wdat, output logic [31:0] rdat);
        bit got;
        got  = 0;
        rdat = '0;
        @(posedge wb_clk_i); #1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = we;
        wb_if.wbs_sel_i = 4'hF;
        wb_if.wbs_adr_i = adr;
        wb_if.wbs_dat_i = wdat;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge wb_clk_i);
            if (wb_if.wbs_ack_o) begin
                got  = 1;
                rdat = wb_if.wbs_dat_o;
            end
        end
        @(posedge wb_clk_i); #1;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        if (!got) begin
            total_cnt++;
            $display("FAIL wb_ack_timeout adr=%h got no ack required ack", adr);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        #1;
        total_cnt++;
        if (wb_if.wbs_ack_o !== 1'b0 || wb_if.wbs_dat_o !== 32'd0 || pt_in_vld !== 1'b0 ||
            pt_px_rdy !== 1'b0 || irq !== 1'b0 || pt_in_dat !== 12'd0)
            $display("FAIL reset_outputs got ack=%b dat=%h vld=%b prdy=%b irq=%b required all 0",
                     wb_if.wbs_ack_o, wb_if.wbs_dat_o, pt_in_vld, pt_px_rdy, irq);
        else pass_cnt++;
        wait_cycles(2);
        wb_rst_i = 1'b0;
        wait_cycles(1);
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r !== 32'h0002_0000) $display("FAIL reset_stat got %h required 00020000", r);
        else pass_cnt++;
        total_cnt++;
        if (pt_px_rdy !== 1'b1) $display("FAIL reset_pxrdy got %b required 1", pt_px_rdy);
        else pass_cnt++;
    endtask

    task automatic test_single_cmd();
        logic [31:0] r;
        int t0;
        pt_in_rdy = 1'b1;
        sent_q.delete(); sent_t.delete();
        vld_cycles = 0;
        t0 = cyc_cnt;
        wb_xfer(1'b1, BASE + 32'h00, 32'h0000_0ABC, r);
        wait_cycles(4);
        total_cnt++;
        if (sent_q.size() != 1 || sent_q[0] !== 12'hABC)
            $display("FAIL single_cmd_data got n=%0d first=%h required n=1 abc",
                     sent_q.size(), (sent_q.size() > 0) ? sent_q[0] : 12'h0);
        else pass_cnt++;
        total_cnt++;
        if (vld_cycles != 1) $display("FAIL single_cmd_vld_len got %0d required 1", vld_cycles);
        else pass_cnt++;
        total_cnt++;
        if (sent_t.size() != 1 || sent_t[0] - t0 > 2 || sent_t[0] - t0 < 1)
            $display("FAIL single_cmd_latency got %0d required 1..2",
                     (sent_t.size() > 0) ? sent_t[0] - t0 : -1);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r[7:0] !== 8'd0) $display("FAIL single_cmd_count got %0d required 0", r[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_cmd_overflow();
        logic [31:0] r;
        @(posedge wb_clk_i); #1;
        pt_in_rdy = 1'b0;
        sent_q.delete(); sent_t.delete();
        for (int i = 1; i <= 9; i++) wb_xfer(1'b1, BASE + 32'h00, i, r);
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r !== 32'h0007_0008) $display("FAIL cmd_ovf_stat got %h required 00070008", r);
        else pass_cnt++;
        total_cnt++;
        if (pt_in_vld !== 1'b1 || pt_in_dat !== 12'h001)
            $display("FAIL cmd_hold got vld=%b dat=%h required 1 001", pt_in_vld, pt_in_dat);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h00, 32'd0, r);
        total_cnt++;
        if (r !== 32'd0) $display("FAIL cmd_read_zero got %h required 0", r);
        else pass_cnt++;
        @(posedge wb_clk_i); #1;
        pt_in_rdy = 1'b1;
        wait_cycles(12);
        total_cnt++;
        if (sent_q.size() != 8) $display("FAIL drain_count got %0d required 8", sent_q.size());
        else pass_cnt++;
        for (int i = 0; i < 8 && i < sent_q.size(); i++) begin
            total_cnt++;
            if (sent_q[i] !== 12'(i + 1) || sent_t[i] != sent_t[0] + i)
                $display("FAIL drain_%0d got dat=%h t=%0d required dat=%h t=%0d",
                         i, sent_q[i], sent_t[i], 12'(i + 1), sent_t[0] + i);
            else pass_cnt++;
        end
        wb_xfer(1'b1, BASE + 32'h08, 32'h0004_0000, r);
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r !== 32'h0002_0000) $display("FAIL ovf_clear got %h required 00020000", r);
        else pass_cnt++;
    endtask

    task automatic test_pixel_fill();
        logic [31:0] r;
        for (int i = 1; i <= 16; i++) begin
            @(posedge wb_clk_i); #1;
            pt_px_vld = 1'b1;
            pt_px_dat = 24'(i);
        end
        @(posedge wb_clk_i); #1;
        pt_px_vld = 1'b0;
        total_cnt++;
        if (pt_px_rdy !== 1'b0) $display("FAIL pix_full_rdy got %b required 0", pt_px_rdy);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h0C, 32'd0, r);
        total_cnt++;
        if (r !== 32'd16) $display("FAIL pcnt_16 got %0d required 16", r);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r !== 32'h0000_1000) $display("FAIL pix_full_stat got %h required 00001000", r);
        else pass_cnt++;
        for (int i = 1; i <= 16; i++) begin
            wb_xfer(1'b0, BASE + 32'h04, 32'd0, r);
            total_cnt++;
            if (r !== (32'h8000_0000 | i))
                $display("FAIL pix_read_%0d got %h required %h", i, r, 32'h8000_0000 | i);
            else pass_cnt++;
        end
        wb_xfer(1'b1, BASE + 32'h14, 32'hFFFF_FFFF, r);
        wb_xfer(1'b0, BASE + 32'h14, 32'd0, r);
        total_cnt++;
        if (r !== 32'd0) $display("FAIL unmapped_read got %h required 0", r);
        else pass_cnt++;
        wb_xfer(1'b0, 32'h4000_0008, 32'd0, r);
        total_cnt++;
        if (r !== 32'd0) $display("FAIL out_of_window got %h required 0", r);
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        logic [31:0] r;
        wb_xfer(1'b0, BASE + 32'h04, 32'd0, r);
        total_cnt++;
        if (r !== 32'd0) $display("FAIL unf_data got %h required 0", r);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r[19] !== 1'b1) $display("FAIL unf_flag got %b required 1", r[19]);
        else pass_cnt++;
        wb_xfer(1'b1, BASE + 32'h08, 32'h0008_0000, r);
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r[19] !== 1'b0) $display("FAIL unf_clear got %b required 0", r[19]);
        else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [31:0] r;
        wb_xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, r);
        wb_xfer(1'b0, BASE + 32'h10, 32'd0, r);
        total_cnt++;
        if (r !== 32'd1) $display("FAIL ctrl_read got %h required 1", r);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_idle got %b required 0", irq);
        else pass_cnt++;
        @(posedge wb_clk_i); #1;
        pt_px_vld = 1'b1;
        pt_px_dat = 24'h123456;
        @(posedge wb_clk_i); #1;
        pt_px_vld = 1'b0;
        wait_cycles(2);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_set got %b required 1", irq);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h04, 32'd0, r);
        total_cnt++;
        if (r !== 32'h8012_3456) $display("FAIL irq_pix got %h required 80123456", r);
        else pass_cnt++;
        wait_cycles(1);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_clear got %b required 0", irq);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h0C, 32'd0, r);
        total_cnt++;
        if (r !== 32'd17) $display("FAIL pcnt_17 got %0d required 17", r);
        else pass_cnt++;
        wb_xfer(1'b1, BASE + 32'h0C, 32'h1234, r);
        wb_xfer(1'b0, BASE + 32'h0C, 32'd0, r);
        total_cnt++;
        if (r !== 32'd0) $display("FAIL pcnt_clear got %0d required 0", r);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r;
        @(posedge wb_clk_i); #1;
        pt_in_rdy = 1'b0;
        for (int i = 0; i < 3; i++) wb_xfer(1'b1, BASE + 32'h00, 32'h100 + i, r);
        total_cnt++;
        if (pt_in_vld !== 1'b1) $display("FAIL pre_reset_vld got %b required 1", pt_in_vld);
        else pass_cnt++;
        @(posedge wb_clk_i); #2;
        wb_rst_i = 1'b1;
        #1;
        total_cnt++;
        if (pt_in_vld !== 1'b0) $display("FAIL reset_drops_vld got %b required 0", pt_in_vld);
        else pass_cnt++;
        wait_cycles(2);
        wb_rst_i = 1'b0;
        wait_cycles(1);
        wb_xfer(1'b0, BASE + 32'h08, 32'd0, r);
        total_cnt++;
        if (r !== 32'h0002_0000) $display("FAIL post_reset_stat got %h required 00020000", r);
        else pass_cnt++;
        wb_xfer(1'b0, BASE + 32'h10, 32'd0, r);
        total_cnt++;
        if (r !== 32'd0) $display("FAIL post_reset_ctrl got %h required 0", r);
        else pass_cnt++;
    endtask

    initial begin
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = 4'h0;
        wb_if.wbs_adr_i = '0;
        wb_if.wbs_dat_i = '0;
        test_reset();
        test_single_cmd();
        test_cmd_overflow();
        test_pixel_fill();
        test_underflow();
        test_irq();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1);
    end

endmodule
